// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared constants for the text-mode glyph pipeline: glyph geometry, character
// ROM address width, fixed pipeline latency, first cursor underline scanline,
// and the default text grid dimensions.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_text_pkg;

   localparam int GLYPH_W           = 8;
   localparam int GLYPH_H           = 16;
   localparam int ROM_AW            = 11;
   localparam int PIPE_LAT          = 5;
   localparam int CURSOR_FIRST_LINE = 14;
   localparam int DEF_COLS          = 80;
   localparam int DEF_ROWS          = 30;

   // Bundle of the timing-generator sideband signals
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;

endpackage

// File: rtl/sig_delay.sv
// -----------------------------------------------------------------------------
// sig_delay
// Fixed-depth shift register with synchronous active-high reset. Used to keep
// sideband and per-pixel control bits aligned with the glyph data pipeline.
// Ports:
//   clk   in            clock
//   reset in            synchronous, active-high; clears every stage
//   din   in  [WIDTH]   value entering the delay line
//   dout  out [WIDTH]   din delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module sig_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/text_glyph_renderer.sv
// -----------------------------------------------------------------------------
// text_glyph_renderer
// Text-mode pixel pipeline: pixel position -> text RAM address -> character
// code -> glyph ROM address -> glyph row -> one monochrome pixel. Sync and
// enable are delayed to stay aligned with the pixel. Fixed 5-clock latency,
// no stalls.
// Optional build macro CURSOR_EN: blinking underline cursor on scanlines
// 14..15 of the cell at (cur_col, cur_row); blink period 2^BLINK_LOG2 frames.
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   de_in, hs_in, vs_in        timing generator enable / syncs
//   hpos, vpos [9:0]           current pixel position
//   tram_addr [TRAM_AW-1:0]    text RAM read address
//   tram_data [7:0]            character code (1 cycle after tram_addr)
//   rom_ad [10:0], rom_ce      glyph ROM address / clock enable
//   rom_dout [7:0]             glyph row (1 cycle after rom_ad), MSB leftmost
//   cur_col [6:0], cur_row[4:0] cursor cell (used only with CURSOR_EN)
//   pix_out                    monochrome pixel
//   de_out, hs_out, vs_out     de_in/hs_in/vs_in delayed 5 clocks
// -----------------------------------------------------------------------------
module text_glyph_renderer
   import vga_text_pkg::*;
#(
   parameter int COLS       = DEF_COLS,
   parameter int ROWS       = DEF_ROWS,
   parameter int TRAM_AW    = 12,
   parameter int BLINK_LOG2 = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               de_in,
   input  logic               hs_in,
   input  logic               vs_in,
   input  logic [9:0]         hpos,
   input  logic [9:0]         vpos,
   output logic [TRAM_AW-1:0] tram_addr,
   input  logic [7:0]         tram_data,
   output logic [10:0]        rom_ad,
   output logic               rom_ce,
   input  logic [7:0]         rom_dout,
   input  logic [6:0]         cur_col,
   input  logic [4:0]         cur_row,
   output logic               pix_out,
   output logic               de_out,
   output logic               hs_out,
   output logic               vs_out
);

   if (COLS * ROWS > (1 << TRAM_AW) || BLINK_LOG2 < 1) begin : g_cfg_check
      $error("text_glyph_renderer: TRAM_AW too small for COLS*ROWS or BLINK_LOG2 < 1");
   end

   logic [TRAM_AW-1:0] addr_p0;
   logic               cursor_p0;
   logic [3:0]         scan_p2;
   logic               de_p4, hs_p4, vs_p4, cursor_p4, inv_p4;
   logic [2:0]         bitsel_p4;

   // Character cell index; wraps silently at TRAM_AW bits
   assign addr_p0 = TRAM_AW'(vpos[8:4]) * TRAM_AW'(COLS) + TRAM_AW'(hpos[9:3]);

`ifdef CURSOR_EN
   logic                  vs_prev;
   logic [BLINK_LOG2-1:0] blink_cnt;
   logic                  unused_vpos;

   // Frame counter advanced on each vsync rising edge; its MSB gives 50% duty
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_prev   <= 1'b0;
         blink_cnt <= '0;
      end else begin
         vs_prev <= vs_in;
         if (vs_in && !vs_prev) blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign cursor_p0 = (hpos[9:3] == cur_col) && (vpos[8:4] == cur_row) &&
                      (vpos[3:0] >= 4'(CURSOR_FIRST_LINE)) && !blink_cnt[BLINK_LOG2-1];
   assign unused_vpos = vpos[9];
`else
   logic unused_in;

   assign cursor_p0 = 1'b0;
   assign unused_in = ^{cur_col, cur_row, vpos[9]};
`endif

   // Scanline is consumed at stage 3 when the ROM address is formed
   sig_delay #(.WIDTH(4), .DEPTH(2)) u_scan (
      .clk   (clk),
      .reset (reset),
      .din   (vpos[3:0]),
      .dout  (scan_p2)
   );

   // Sideband and per-pixel control carried to the output stage
   sig_delay #(.WIDTH(7), .DEPTH(PIPE_LAT - 1)) u_side (
      .clk   (clk),
      .reset (reset),
      .din   ({de_in, hs_in, vs_in, hpos[2:0], cursor_p0}),
      .dout  ({de_p4, hs_p4, vs_p4, bitsel_p4, cursor_p4})
   );

   // Reverse-video bit enters at stage 3 alongside rom_ad
   sig_delay #(.WIDTH(1), .DEPTH(2)) u_inv (
      .clk   (clk),
      .reset (reset),
      .din   (tram_data[7]),
      .dout  (inv_p4)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         tram_addr <= '0;
         rom_ad    <= '0;
         rom_ce    <= 1'b0;
         pix_out   <= 1'b0;
         de_out    <= 1'b0;
         hs_out    <= 1'b0;
         vs_out    <= 1'b0;
      end else begin
         // stage 1: text RAM address
         tram_addr <= addr_p0;
         // stage 3: glyph ROM address from fetched code
         rom_ad    <= {tram_data[6:0], scan_p2};
         rom_ce    <= 1'b1;
         // stage 5: pixel select and output sideband
         pix_out   <= de_p4 ? (rom_dout[3'd7 - bitsel_p4] ^ inv_p4 ^ cursor_p4) : 1'b0;
         de_out    <= de_p4;
         hs_out    <= hs_p4;
         vs_out    <= vs_p4;
      end
   end

endmodule

// File: tb/tb_text_glyph_renderer.sv
// -----------------------------------------------------------------------------
// tb_text_glyph_renderer
// Self-checking bench for text_glyph_renderer with behavioural text RAM and
// glyph ROM models (1-cycle registered reads). Expected outputs are computed
// from the memory contents when each pixel is driven and queued; they are
// compared with the DUT outputs 5 clocks later. Build with CURSOR_EN defined
// to include the cursor scenario.
// -----------------------------------------------------------------------------
module tb_text_glyph_renderer;

   localparam int LAT = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        de_in, hs_in, vs_in;
   logic [9:0]  hpos, vpos;
   logic [11:0] tram_addr;
   logic [7:0]  tram_data = 8'h00;
   logic [10:0] rom_ad;
   logic        rom_ce;
   logic [7:0]  rom_dout = 8'h00;
   logic [6:0]  cur_col;
   logic [4:0]  cur_row;
   logic        pix_out, de_out, hs_out, vs_out;

   logic [7:0]  tram [4096];
   logic [7:0]  rom  [2048];

   logic [3:0]  exp_q [$];
   logic [3:0]  chk_q [$];
   logic [3:0]  act_q [$];

   int vectors = 0;
   int errors  = 0;

`ifdef CURSOR_EN
   logic [4:0] tb_blink;
   logic       tb_vs_prev;
`endif

   text_glyph_renderer dut (
      .clk       (clk),
      .reset     (reset),
      .de_in     (de_in),
      .hs_in     (hs_in),
      .vs_in     (vs_in),
      .hpos      (hpos),
      .vpos      (vpos),
      .tram_addr (tram_addr),
      .tram_data (tram_data),
      .rom_ad    (rom_ad),
      .rom_ce    (rom_ce),
      .rom_dout  (rom_dout),
      .cur_col   (cur_col),
      .cur_row   (cur_row),
      .pix_out   (pix_out),
      .de_out    (de_out),
      .hs_out    (hs_out),
      .vs_out    (vs_out)
   );

   always #5 clk = ~clk;

   // Memory models
   always @(posedge clk) begin
      tram_data <= tram[tram_addr];
      if (rom_ce) rom_dout <= rom[rom_ad];
   end

   // Empties the pipeline model after a reset: the first 4 outputs are zeros
   task automatic model_flush();
      exp_q.delete();
      chk_q.delete();
      act_q.delete();
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back(4'b0000);
`ifdef CURSOR_EN
      tb_blink   = '0;
      tb_vs_prev = 1'b0;
`endif
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; hpos = '0; vpos = '0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      model_flush();
   endtask

   // Drive one pixel, queue its expected output, advance one clock
   task automatic step(input logic de, input logic hs, input logic vs,
                       input logic [9:0] h, input logic [9:0] v);
      int         a;
      int         b;
      logic [7:0] code;
      logic [7:0] row;
      logic       cur;
      logic       pix;
      de_in = de; hs_in = hs; vs_in = vs; hpos = h; vpos = v;
      a    = (int'(v[8:4]) * 80 + int'(h[9:3])) % 4096;
      code = tram[a];
      row  = rom[{code[6:0], v[3:0]}];
      b    = 7 - int'(h[2:0]);
      cur  = 1'b0;
`ifdef CURSOR_EN
      cur = (h[9:3] == cur_col) && (v[8:4] == cur_row) && (v[3:0] >= 4'd14) && !tb_blink[4];
`endif
      pix = de ? (row[b] ^ code[7] ^ cur) : 1'b0;
      exp_q.push_back({pix, de, hs, vs});
      @(posedge clk);
      #1;
`ifdef CURSOR_EN
      if (vs && !tb_vs_prev) tb_blink = tb_blink + 5'd1;
      tb_vs_prev = vs;
`endif
      if (exp_q.size() >= LAT) begin
         chk_q.push_back(exp_q.pop_front());
         act_q.push_back({pix_out, de_out, hs_out, vs_out});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   task automatic test_reset();
      logic [3:0] a, e;
      for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
      vectors++;
      if ({pix_out, de_out, hs_out, vs_out, rom_ce} !== 5'b0 || tram_addr !== 12'd0 || rom_ad !== 11'd0) begin
         errors++;
         $display("FAIL reset_state: got pix/de/hs/vs/ce=%b addr=%0d rom_ad=%h, required all 0",
                  {pix_out, de_out, hs_out, vs_out, rom_ce}, tram_addr, rom_ad);
      end
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 10'(i), 10'd37);
      while (act_q.size() > 0) begin
         a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
         if (a !== e) begin
            errors++;
            $display("FAIL pre_reset: got %b required %b", a, e);
         end
      end
      // Reset during active video
      reset = 1'b1;
      de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1; hpos = 10'd8; vpos = 10'd37;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({pix_out, de_out, hs_out, vs_out, rom_ce} !== 5'b0 || tram_addr !== 12'd0 || rom_ad !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset[%0d]: got pix/de/hs/vs/ce=%b addr=%0d rom_ad=%h, required all 0",
                     i, {pix_out, de_out, hs_out, vs_out, rom_ce}, tram_addr, rom_ad);
         end
      end
      reset = 1'b0;
      model_flush();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b1, 10'(i), 10'd37);
         if (i == 0) begin
            vectors++;
            if (rom_ce !== 1'b1) begin
               errors++;
               $display("FAIL rom_ce_release: got %b required 1", rom_ce);
            end
         end
      end
      idle(4);
      while (act_q.size() > 0) begin
         a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
         if (a !== e) begin
            errors++;
            $display("FAIL post_reset: got %b required %b", a, e);
         end
      end
   endtask

   task automatic test_addr();
      logic [3:0] a, e;
      for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
      rom[11'h415] = 8'h81;
      tram[162]    = 8'h41;
      step(1'b1, 1'b0, 1'b0, 10'd17, 10'd37);
      vectors++;
      if (tram_addr !== 12'd162) begin
         errors++;
         $display("FAIL tram_addr: got %0d required 162", tram_addr);
      end
      idle(2);
      vectors++;
      if (rom_ad !== 11'h415) begin
         errors++;
         $display("FAIL rom_ad: got %h required 415", rom_ad);
      end
      idle(4);
      while (act_q.size() > 0) begin
         a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
         if (a !== e) begin
            errors++;
            $display("FAIL addr_pix: got %b required %b", a, e);
         end
      end
   endtask

   task automatic test_glyph();
      logic [3:0] a, e;
      for (int pass = 0; pass < 2; pass++) begin
         tram[162] = (pass == 0) ? 8'h41 : 8'hC1;
         for (int h = 16; h < 24; h++) begin
            step(1'b1, 1'b0, 1'b0, 10'(h), 10'd37);
            if (h == 18) begin
               vectors++;
               if (rom_ad !== 11'h415) begin
                  errors++;
                  $display("FAIL glyph_rom_ad[%0d]: got %h required 415", pass, rom_ad);
               end
            end
         end
         idle(4);
         while (act_q.size() > 0) begin
            a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
            if (a !== e) begin
               errors++;
               $display("FAIL glyph_pix[%0d]: got %b required %b", pass, a, e);
            end
         end
      end
   endtask

   task automatic test_blank();
      logic [3:0] a, e;
      for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
      tram[162] = 8'hC1;
      for (int i = 0; i < 24; i++)
         step(1'b0, 1'($urandom), 1'($urandom), 10'($urandom_range(639)), 10'($urandom_range(479)));
      idle(4);
      while (act_q.size() > 0) begin
         a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
         if (a !== e) begin
            errors++;
            $display("FAIL blank: got %b required %b", a, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] a, e;
      logic [9:0] h, v;
      for (int i = 0; i < 2400; i++) tram[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) rom[i]  = 8'($urandom);
      h = 10'd600; v = 10'd15;
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(7) != 0), 1'($urandom), 1'($urandom), h, v);
         if ($urandom_range(15) == 0) begin
            h = 10'($urandom_range(639));
            v = 10'($urandom_range(479));
         end else if (h == 10'd639) begin
            h = 10'd0;
            v = (v == 10'd479) ? 10'd0 : v + 10'd1;
         end else begin
            h = h + 10'd1;
         end
      end
      idle(4);
      while (act_q.size() > 0) begin
         a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
         if (a !== e) begin
            errors++;
            $display("FAIL back_to_back: got %b required %b", a, e);
         end
      end
   endtask

`ifdef CURSOR_EN
   task automatic vs_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
         step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
      end
   endtask

   task automatic test_cursor();
      logic [3:0] a, e;
      cur_col = 7'd2;
      cur_row = 5'd2;
      do_reset(1);
      tram[162]    = 8'h41;
      rom[11'h41E] = 8'h00;
      rom[11'h41D] = 8'h00;
      for (int phase = 0; phase < 3; phase++) begin
         for (int h = 16; h < 24; h++) step(1'b1, 1'b0, 1'b0, 10'(h), 10'd46);
         if (phase == 2)
            for (int h = 16; h < 24; h++) step(1'b1, 1'b0, 1'b0, 10'(h), 10'd45);
         idle(4);
         while (act_q.size() > 0) begin
            a = act_q.pop_front(); e = chk_q.pop_front(); vectors++;
            if (a !== e) begin
               errors++;
               $display("FAIL cursor[%0d]: got %b required %b", phase, a, e);
            end
         end
         vs_pulses(16);
      end
      cur_col = 7'd127;
      cur_row = 5'd31;
   endtask
`endif

   initial begin
      cur_col = 7'd127;
      cur_row = 5'd31;
      for (int i = 0; i < 4096; i++) tram[i] = 8'h00;
      for (int i = 0; i < 2048; i++) rom[i]  = 8'h00;
      do_reset(2);
      test_reset();
      test_addr();
      test_glyph();
      test_blank();
      test_back_to_back();
`ifdef CURSOR_EN
      test_cursor();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/text_glyph_renderer.md
Name: text_glyph_renderer

Overview:
- Text-mode pixel pipeline between the VGA timing generator and the display output.
- Each active pixel is processed as follows:
  - The block converts the pixel position to a text-buffer address.
  - It fetches the character code.
  - It forms the 11-bit glyph ROM address for that code and the current scanline.
  - It selects one bit of the returned glyph row.
- Sync and enable signals are delayed so they stay aligned with the pixel.
- The block drives the character ROM directly. The ROM is 128 glyphs × 16 rows × 8 bits with 1-cycle registered read.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows per frame.
- TRAM_AW, 12, text RAM address width (must hold COLS*ROWS-1).
- BLINK_LOG2, 5, cursor blink period = 2^BLINK_LOG2 frames (50% duty).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- de_in  in  1  active-video enable from timing generator
- hs_in  in  1  hsync from timing generator
- vs_in  in  1  vsync from timing generator, active-high
- hpos  in  10  pixel x (0..639 when active)
- vpos  in  10  pixel y (0..479 when active)
- tram_addr  out  TRAM_AW  text RAM read address
- tram_data  in  8  character code, valid exactly 1 cycle after tram_addr
- rom_ad  out  11  glyph ROM address {code[6:0], scanline[3:0]}
- rom_ce  out  1  ROM clock enable (also drives ROM oce)
- rom_dout  in  8  glyph row, valid 1 cycle after rom_ad, MSB = leftmost pixel
- cur_col  in  7  cursor column
- cur_row  in  5  cursor row
- pix_out  out  1  monochrome pixel
- de_out, hs_out, vs_out  out  1 each  delayed copies of de_in/hs_in/vs_in

Behaviour:
- Reset: all outputs, pipeline registers and the blink counter go to 0 on the first clk edge with reset high. rom_ce = 1 from the first cycle after reset deasserts.
- Stage 1 (edge 1): tram_addr <= vpos[8:4]*COLS + hpos[9:3]. The product is computed at TRAM_AW bits with no wrap check; inputs outside the active area are don't-care.
  - Also captured at this stage: scanline = vpos[3:0], bitsel = hpos[2:0], de/hs/vs.
- Stage 2 (edge 2): text RAM registers tram_data. Sideband signals are delayed 1 more cycle.
- Stage 3 (edge 3): rom_ad <= {tram_data[6:0], scanline}. The block also registers inv = tram_data[7], which selects reverse video.
- Stage 4 (edge 4): the ROM presents rom_dout. Sideband signals are delayed.
- Stage 5 (edge 5): pix_out <= de_d4 ? (rom_dout[7-bitsel_d4] ^ inv_d4 ^ cursor_d4) : 0.
  - de_out, hs_out and vs_out are the inputs delayed by exactly 5 cycles.
- Total latency is 5 clocks from inputs to pix_out and syncs; this value is fixed.
- de low: pix_out = 0 regardless of rom_dout, inv and cursor.
- The pipeline advances every cycle with no stall and no backpressure.
- Reset asserted mid-frame: the next edge clears everything. After release, the first 5 output cycles are 0/inactive; output is valid from the 6th cycle onward.
- hpos/vpos jumping (e.g. line wrap): each stage carries its own copy of position and delayed data, so no state is corrupted.

Optional Feature:
- Macro CURSOR_EN.
- Defined:
  - blink_cnt (BLINK_LOG2 bits) increments on each rising edge of vs_in, detected via a registered vs_in, and wraps to 0.
  - cursor = (hpos[9:3]==cur_col) && (vpos[8:4]==cur_row) && (vpos[3:0]>=14) && !blink_cnt[BLINK_LOG2-1]. It is evaluated at stage 1 and carried to stage 5.
  - The result is an underline on scanlines 14–15 of the cursor cell, XORed into the pixel.
- Undefined:
  - cursor is constant 0 and there is no blink counter.
  - cur_col and cur_row remain as ports but are ignored.

Decomposition:
- Package vga_text_pkg:
  - GLYPH_W=8, GLYPH_H=16, ROM_AW=11.
  - PIPE_LAT=5.
  - CURSOR_FIRST_LINE=14.
  - Default COLS/ROWS.
- Sub-module sig_delay (parameters WIDTH, DEPTH): a synchronous-reset shift register used for the {de,hs,vs} delay line and the bitsel/inv/cursor side pipeline.

Test Plan:
- Reset for 3 cycles during active video, with rom_dout=FF and de_in=1 → pix_out, de_out, hs_out, vs_out all 0. After release, they stay 0 for 5 cycles, then pix_out=1.
- hpos=17, vpos=37, de_in=1 → tram_addr=162 one cycle later. Then tram_data=8'h41 → rom_ad=11'h415 at edge 3.
- Cell at hpos 16..23 with rom_dout=8'h81 and code bit7=0 → pix_out sequence 1,0,0,0,0,0,0,1, starting exactly 5 cycles after hpos=16.
- Same cell with tram_data=8'hC1 → rom_ad=11'h415 and pix_out sequence 0,1,1,1,1,1,1,0.
- de_in=0 with rom_dout=FF and hs/vs toggling → pix_out=0, and hs_out/vs_out equal hs_in/vs_in delayed exactly 5 cycles.
- CURSOR_EN with cur_col=2, cur_row=2, vpos=46, hpos=16..23, glyph row 00, blink_cnt=0 → pix_out all 1. After 16 vs_in rising edges → all 0. On vpos=45 → 0.
